// File: rtl/tlb_pkg.sv
// Shared types and constants for the joint TLB: op and exception codes,
// the stored entry layout and CP0 EntryHi/EntryLo field positions.
package tlb_pkg;

    localparam int TLB_VPN_W  = 19;
    localparam int TLB_PFN_W  = 24;
    localparam int TLB_ASID_W = 8;

    // CP0 op codes presented on op
    localparam logic [2:0] TLB_OP_TLBR  = 3'b001;
    localparam logic [2:0] TLB_OP_TLBWI = 3'b010;
    localparam logic [2:0] TLB_OP_TLBWR = 3'b011;
    localparam logic [2:0] TLB_OP_TLBP  = 3'b100;

    // Lookup exception classification
    localparam logic [1:0] EXC_NONE    = 2'b00;
    localparam logic [1:0] EXC_REFILL  = 2'b01;
    localparam logic [1:0] EXC_INVALID = 2'b10;
    localparam logic [1:0] EXC_MOD     = 2'b11;

    // EntryHi / EntryLo field positions
    localparam int EHI_VPN2_LSB = 13;
    localparam int EHI_ASID_LSB = 0;
    localparam int ELO_PFN_LSB  = 6;
    localparam int ELO_C_LSB    = 3;
    localparam int ELO_D_BIT    = 2;
    localparam int ELO_V_BIT    = 1;
    localparam int ELO_G_BIT    = 0;

    typedef struct packed {
        logic [TLB_VPN_W-1:0]  vpn2;
        logic [TLB_ASID_W-1:0] asid;
        logic                  g;
        logic [TLB_PFN_W-1:0]  pfn0;
        logic [2:0]            c0;
        logic                  d0;
        logic                  v0;
        logic [TLB_PFN_W-1:0]  pfn1;
        logic [2:0]            c1;
        logic                  d1;
        logic                  v1;
    } tlb_entry_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EXEC = 1'b1
    } tlb_state_t;

    // Rebuild a CP0 EntryLo word from one stored page
    function automatic logic [31:0] pack_lo(input logic [TLB_PFN_W-1:0] pfn,
                                            input logic [2:0] c,
                                            input logic d,
                                            input logic v,
                                            input logic g);
        return {2'b00, pfn, c, d, v, g};
    endfunction

endpackage

// File: rtl/tlb_match.sv
// Fully-associative compare of one VPN2/ASID key against every entry,
// followed by a priority encoder so the lowest matching index wins.
module tlb_match
    import tlb_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = $clog2(ENTRIES),
    parameter int VPN_W   = 19,
    parameter int ASID_W  = 8
) (
    input  tlb_entry_t        entries [ENTRIES],
    input  logic [VPN_W-1:0]  vpn2,
    input  logic [ASID_W-1:0] asid,
    output logic              hit,
    output logic [IDX_W-1:0]  idx
);

    logic [ENTRIES-1:0] match_vec;

    generate
        for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_cmp
            assign match_vec[gi] = (entries[gi].vpn2 == vpn2) &&
                                   (entries[gi].g || (entries[gi].asid == asid)) &&
                                   (entries[gi].v0 || entries[gi].v1);
        end
    endgenerate

    // Priority encode: scanning downward leaves the lowest match in idx
    always_comb begin
        hit = |match_vec;
        idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (match_vec[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/tlb_array.sv
// Joint TLB: registered instruction/data lookups every cycle, CP0 op engine
// (TLBR/TLBWI/TLBWR/TLBP) behind an op/done handshake, and Random/Wired.
module tlb_array
    import tlb_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = $clog2(ENTRIES),
    parameter int VPN_W   = 19,
    parameter int PFN_W   = 24,
    parameter int ASID_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [19:0]       i_va,
    input  logic              i_unmapped,
    input  logic              d_req,
    input  logic [19:0]       d_va,
    input  logic              d_store,
    input  logic              d_unmapped,
    input  logic [ASID_W-1:0] asid,
    output logic [PFN_W-1:0]  i_pfn,
    output logic [2:0]        i_cattr,
    output logic [1:0]        i_exc,
    output logic              i_vld,
    output logic [PFN_W-1:0]  d_pfn,
    output logic [2:0]        d_cattr,
    output logic [1:0]        d_exc,
    output logic              d_vld,
    input  logic [2:0]        op,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [IDX_W-1:0]  index_in,
    input  logic [31:0]       entryhi_in,
    input  logic [31:0]       entrylo0_in,
    input  logic [31:0]       entrylo1_in,
    input  logic              wired_we,
    input  logic [IDX_W-1:0]  wired_in,
    output logic [IDX_W-1:0]  random_out,
    output logic              op_done,
    output logic [31:0]       rd_entryhi,
    output logic [31:0]       rd_entrylo0,
    output logic [31:0]       rd_entrylo1,
    output logic [31:0]       probe_index
);

    localparam logic [IDX_W-1:0] RAND_MAX  = IDX_W'(ENTRIES - 1);
    localparam logic [31:0]      PROBE_MISS = 32'h8000_0000;

    tlb_entry_t        entries [ENTRIES];
    tlb_state_t        state_reg, state_next;
    logic [2:0]        op_reg;
    logic [IDX_W-1:0]  index_reg, rand_lat_reg;
    tlb_entry_t        wr_entry_reg, op_entry_next;
    logic [IDX_W-1:0]  wired_reg, random_reg;
    logic [IDX_W:0]    wired_p1;
    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    logic [ENTRIES-1:0] wr_sel;
    logic              i_hit, d_hit, p_hit;
    logic [IDX_W-1:0]  i_idx, d_idx, p_idx;
    logic [PFN_W-1:0]  i_pfn_next, d_pfn_next;
    logic [2:0]        i_cattr_next, d_cattr_next;
    logic [1:0]        i_exc_next, d_exc_next;
    logic              unused_bits;

    // Reserved EntryHi bits and EntryLo fill bits carry no state
    assign unused_bits = ^{entryhi_in[EHI_VPN2_LSB-1:TLB_ASID_W],
                           entrylo0_in[31:30], entrylo1_in[31:30]};

    // ---------------- lookup units ----------------
    tlb_match #(.ENTRIES(ENTRIES), .IDX_W(IDX_W), .VPN_W(VPN_W), .ASID_W(ASID_W)) u_imatch (
        .entries(entries), .vpn2(i_va[19:1]), .asid(asid), .hit(i_hit), .idx(i_idx));
    tlb_match #(.ENTRIES(ENTRIES), .IDX_W(IDX_W), .VPN_W(VPN_W), .ASID_W(ASID_W)) u_dmatch (
        .entries(entries), .vpn2(d_va[19:1]), .asid(asid), .hit(d_hit), .idx(d_idx));
    // Probe key is the EntryHi latched when the op was accepted
    tlb_match #(.ENTRIES(ENTRIES), .IDX_W(IDX_W), .VPN_W(VPN_W), .ASID_W(ASID_W)) u_pmatch (
        .entries(entries), .vpn2(wr_entry_reg.vpn2), .asid(wr_entry_reg.asid),
        .hit(p_hit), .idx(p_idx));

    // Instruction page select and exception classification
    always_comb begin
        i_pfn_next   = '0;
        i_cattr_next = '0;
        i_exc_next   = EXC_NONE;
        if (!i_unmapped) begin
            if (!i_hit) begin
                i_exc_next = EXC_REFILL;
            end else begin
                i_pfn_next   = i_va[0] ? entries[i_idx].pfn1 : entries[i_idx].pfn0;
                i_cattr_next = i_va[0] ? entries[i_idx].c1 : entries[i_idx].c0;
                if (!(i_va[0] ? entries[i_idx].v1 : entries[i_idx].v0)) begin
                    i_exc_next = EXC_INVALID;
                end
            end
        end
    end

    // Data page select; a store to a clean valid page raises modified
    always_comb begin
        d_pfn_next   = '0;
        d_cattr_next = '0;
        d_exc_next   = EXC_NONE;
        if (!d_unmapped) begin
            if (!d_hit) begin
                d_exc_next = EXC_REFILL;
            end else begin
                d_pfn_next   = d_va[0] ? entries[d_idx].pfn1 : entries[d_idx].pfn0;
                d_cattr_next = d_va[0] ? entries[d_idx].c1 : entries[d_idx].c0;
                if (!(d_va[0] ? entries[d_idx].v1 : entries[d_idx].v0)) begin
                    d_exc_next = EXC_INVALID;
                end else if (d_store && !(d_va[0] ? entries[d_idx].d1 : entries[d_idx].d0)) begin
                    d_exc_next = EXC_MOD;
                end
            end
        end
    end

    // Register lookup results; valid flags follow the request one cycle later
    always_ff @(posedge clk) begin
        if (!rst) begin
            i_vld <= 1'b0; i_pfn <= '0; i_cattr <= '0; i_exc <= EXC_NONE;
            d_vld <= 1'b0; d_pfn <= '0; d_cattr <= '0; d_exc <= EXC_NONE;
        end else begin
            i_vld <= i_req; i_pfn <= i_pfn_next; i_cattr <= i_cattr_next; i_exc <= i_exc_next;
            d_vld <= d_req; d_pfn <= d_pfn_next; d_cattr <= d_cattr_next; d_exc <= d_exc_next;
        end
    end

    // ---------------- Random / Wired ----------------
    assign wired_p1   = {1'b0, wired_reg} + {{IDX_W{1'b0}}, 1'b1};
    assign random_out = random_reg;

    // Random counts down and wraps before it would reach Wired
    always_ff @(posedge clk) begin
        if (!rst) begin
            wired_reg  <= '0;
            random_reg <= RAND_MAX;
        end else if (wired_we) begin
            wired_reg  <= wired_in;
            random_reg <= RAND_MAX;
        end else if ({1'b0, random_reg} <= wired_p1) begin
            random_reg <= RAND_MAX;
        end else begin
            random_reg <= random_reg - 1'b1;
        end
    end

    // ---------------- op engine ----------------
    // Decode CP0 registers into the stored entry layout
    always_comb begin
        op_entry_next      = '0;
        op_entry_next.vpn2 = entryhi_in[EHI_VPN2_LSB +: TLB_VPN_W];
        op_entry_next.asid = entryhi_in[EHI_ASID_LSB +: TLB_ASID_W];
        op_entry_next.g    = entrylo0_in[ELO_G_BIT] & entrylo1_in[ELO_G_BIT];
        op_entry_next.pfn0 = entrylo0_in[ELO_PFN_LSB +: TLB_PFN_W];
        op_entry_next.c0   = entrylo0_in[ELO_C_LSB +: 3];
        op_entry_next.d0   = entrylo0_in[ELO_D_BIT];
        op_entry_next.v0   = entrylo0_in[ELO_V_BIT];
        op_entry_next.pfn1 = entrylo1_in[ELO_PFN_LSB +: TLB_PFN_W];
        op_entry_next.c1   = entrylo1_in[ELO_C_LSB +: 3];
        op_entry_next.d1   = entrylo1_in[ELO_D_BIT];
        op_entry_next.v1   = entrylo1_in[ELO_V_BIT];
    end

    // Next-state and handshake: one EXEC cycle per accepted op
    always_comb begin
        state_next = state_reg;
        op_ready   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                op_ready = 1'b1;
                if (op_valid) state_next = ST_EXEC;
            end
            ST_EXEC: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst) state_reg <= ST_IDLE;
        else      state_reg <= state_next;
    end

    // Capture the op and its operands, including Random, on acceptance
    always_ff @(posedge clk) begin
        if (!rst) begin
            op_reg       <= '0;
            index_reg    <= '0;
            rand_lat_reg <= '0;
            wr_entry_reg <= '0;
        end else if (state_reg == ST_IDLE && op_valid) begin
            op_reg       <= op;
            index_reg    <= index_in;
            rand_lat_reg <= random_reg;
            wr_entry_reg <= op_entry_next;
        end
    end

    assign wr_en  = (state_reg == ST_EXEC) &&
                    (op_reg == TLB_OP_TLBWI || op_reg == TLB_OP_TLBWR);
    assign wr_idx = (op_reg == TLB_OP_TLBWR) ? rand_lat_reg : index_reg;

    generate
        for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_wsel
            assign wr_sel[gi] = wr_en && (wr_idx == IDX_W'(gi));
        end
    endgenerate

    // Entry storage: cleared on reset, one entry written per TLBWI/TLBWR
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) entries[i] <= '0;
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (wr_sel[i]) entries[i] <= wr_entry_reg;
            end
        end
    end

    // Read/probe results and the completion pulse, all landing together
    always_ff @(posedge clk) begin
        if (!rst) begin
            op_done     <= 1'b0;
            rd_entryhi  <= '0;
            rd_entrylo0 <= '0;
            rd_entrylo1 <= '0;
            probe_index <= PROBE_MISS;
        end else begin
            op_done <= (state_reg == ST_EXEC);
            if (state_reg == ST_EXEC) begin
                case (op_reg)
                    TLB_OP_TLBR: begin
                        rd_entryhi  <= {entries[index_reg].vpn2, 5'b0, entries[index_reg].asid};
                        rd_entrylo0 <= pack_lo(entries[index_reg].pfn0, entries[index_reg].c0,
                                               entries[index_reg].d0, entries[index_reg].v0,
                                               entries[index_reg].g);
                        rd_entrylo1 <= pack_lo(entries[index_reg].pfn1, entries[index_reg].c1,
                                               entries[index_reg].d1, entries[index_reg].v1,
                                               entries[index_reg].g);
                    end
                    TLB_OP_TLBP: probe_index <= p_hit ? 32'(p_idx) : PROBE_MISS;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tlb_array.sv
// Directed bench for tlb_array: lookups, CP0 ops, Random/Wired, reset in EXEC.
module tb_tlb_array;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, i_unmapped, d_req, d_store, d_unmapped;
    logic [19:0] i_va, d_va;
    logic [7:0]  asid;
    logic [23:0] i_pfn, d_pfn;
    logic [2:0]  i_cattr, d_cattr;
    logic [1:0]  i_exc, d_exc;
    logic        i_vld, d_vld;
    logic [2:0]  op;
    logic        op_valid, op_ready, op_done;
    logic [3:0]  index_in, wired_in, random_out;
    logic [31:0] entryhi_in, entrylo0_in, entrylo1_in;
    logic        wired_we;
    logic [31:0] rd_entryhi, rd_entrylo0, rd_entrylo1, probe_index;

    int n_cmp = 0;
    int n_bad = 0;

    tlb_array dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_va(i_va), .i_unmapped(i_unmapped),
        .d_req(d_req), .d_va(d_va), .d_store(d_store), .d_unmapped(d_unmapped),
        .asid(asid),
        .i_pfn(i_pfn), .i_cattr(i_cattr), .i_exc(i_exc), .i_vld(i_vld),
        .d_pfn(d_pfn), .d_cattr(d_cattr), .d_exc(d_exc), .d_vld(d_vld),
        .op(op), .op_valid(op_valid), .op_ready(op_ready),
        .index_in(index_in), .entryhi_in(entryhi_in),
        .entrylo0_in(entrylo0_in), .entrylo1_in(entrylo1_in),
        .wired_we(wired_we), .wired_in(wired_in), .random_out(random_out),
        .op_done(op_done), .rd_entryhi(rd_entryhi), .rd_entrylo0(rd_entrylo0),
        .rd_entrylo1(rd_entrylo1), .probe_index(probe_index)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issue one op and wait (bounded) for its completion pulse
    task automatic do_op(input logic [2:0] o, input logic [3:0] idx,
                         input logic [31:0] hi, input logic [31:0] lo0, input logic [31:0] lo1);
        bit seen;
        op = o; index_in = idx; entryhi_in = hi; entrylo0_in = lo0; entrylo1_in = lo1;
        op_valid = 1'b1;
        tick;
        op_valid = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 5 && !seen; n++) begin
            tick;
            if (op_done === 1'b1) seen = 1'b1;
        end
        n_cmp++;
        if (!seen) begin
            n_bad++;
            $display("FAIL op_done_timeout: op=%0d got no op_done required op_done=1", o);
        end
        $display("op=%0d idx=%0d hi=%h lo0=%h lo1=%h probe=%h rd_hi=%h", o, idx, hi, lo0, lo1,
                 probe_index, rd_entryhi);
    endtask

    task automatic test_reset;
        rst = 1'b0;
        tick; tick;
        rst = 1'b1;
        n_cmp++; if (random_out !== 4'd15) begin n_bad++; $display("FAIL rst_random: got %0d required 15", random_out); end
        n_cmp++; if (op_ready !== 1'b1) begin n_bad++; $display("FAIL rst_op_ready: got %b required 1", op_ready); end
        n_cmp++; if (op_done !== 1'b0) begin n_bad++; $display("FAIL rst_op_done: got %b required 0", op_done); end
        n_cmp++; if (probe_index !== 32'h8000_0000) begin n_bad++; $display("FAIL rst_probe: got %h required 80000000", probe_index); end
        n_cmp++; if ({i_vld, d_vld, i_exc, d_exc} !== 6'b0) begin n_bad++; $display("FAIL rst_lookup_out: got %b required 0", {i_vld, d_vld, i_exc, d_exc}); end
        n_cmp++; if (rd_entryhi !== 32'h0) begin n_bad++; $display("FAIL rst_rd_hi: got %h required 0", rd_entryhi); end
        i_req = 1'b1; i_va = 20'h12345; d_req = 1'b1; d_va = 20'h00800; asid = 8'd0;
        tick;
        $display("lookup after reset: i_exc=%b d_exc=%b", i_exc, d_exc);
        n_cmp++; if (i_vld !== 1'b1) begin n_bad++; $display("FAIL rst_i_vld: got %b required 1", i_vld); end
        n_cmp++; if (i_exc !== 2'b01) begin n_bad++; $display("FAIL rst_i_refill: got %b required 01", i_exc); end
        n_cmp++; if (d_exc !== 2'b01) begin n_bad++; $display("FAIL rst_d_refill: got %b required 01", d_exc); end
        n_cmp++; if (i_pfn !== 24'h0) begin n_bad++; $display("FAIL rst_i_pfn: got %h required 0", i_pfn); end
        i_req = 1'b0; d_req = 1'b0;
        do_op(3'b100, 4'd0, 32'h0080_0005, 32'h0, 32'h0);
        n_cmp++; if (probe_index !== 32'h8000_0000) begin n_bad++; $display("FAIL rst_probe_miss: got %h required 80000000", probe_index); end
    endtask

    task automatic test_lookup_basic;
        do_op(3'b010, 4'd3, 32'h0080_0005, 32'h0000_48DA, 32'h0);
        asid = 8'd5; i_req = 1'b1; i_va = 20'h00800;
        tick;
        $display("ifetch va=%h asid=%0d pfn=%h exc=%b", i_va, asid, i_pfn, i_exc);
        n_cmp++; if (i_pfn !== 24'h123) begin n_bad++; $display("FAIL i_hit_pfn: got %h required 123", i_pfn); end
        n_cmp++; if (i_exc !== 2'b00) begin n_bad++; $display("FAIL i_hit_exc: got %b required 00", i_exc); end
        n_cmp++; if (i_cattr !== 3'd3) begin n_bad++; $display("FAIL i_hit_cattr: got %0d required 3", i_cattr); end
        i_va = 20'h00801;
        tick;
        $display("ifetch va=%h asid=%0d exc=%b", i_va, asid, i_exc);
        n_cmp++; if (i_exc !== 2'b10) begin n_bad++; $display("FAIL i_invalid: got %b required 10", i_exc); end
        i_va = 20'h00800; asid = 8'd6;
        tick;
        $display("ifetch va=%h asid=%0d exc=%b", i_va, asid, i_exc);
        n_cmp++; if (i_exc !== 2'b01) begin n_bad++; $display("FAIL i_asid_refill: got %b required 01", i_exc); end
        n_cmp++; if (i_pfn !== 24'h0) begin n_bad++; $display("FAIL i_refill_pfn: got %h required 0", i_pfn); end
        i_va = 20'h12345; i_unmapped = 1'b1;
        tick;
        $display("ifetch unmapped va=%h exc=%b", i_va, i_exc);
        n_cmp++; if (i_exc !== 2'b00) begin n_bad++; $display("FAIL i_unmapped: got %b required 00", i_exc); end
        i_unmapped = 1'b0; i_req = 1'b0; asid = 8'd5;
    endtask

    task automatic test_data;
        d_req = 1'b1; d_va = 20'h00800; d_store = 1'b1; asid = 8'd5;
        tick;
        $display("store va=%h exc=%b", d_va, d_exc);
        n_cmp++; if (d_exc !== 2'b11) begin n_bad++; $display("FAIL d_modified: got %b required 11", d_exc); end
        d_store = 1'b0;
        tick;
        $display("load va=%h pfn=%h exc=%b", d_va, d_pfn, d_exc);
        n_cmp++; if (d_exc !== 2'b00) begin n_bad++; $display("FAIL d_load_exc: got %b required 00", d_exc); end
        n_cmp++; if (d_pfn !== 24'h123) begin n_bad++; $display("FAIL d_load_pfn: got %h required 123", d_pfn); end
        n_cmp++; if (d_vld !== 1'b1) begin n_bad++; $display("FAIL d_vld: got %b required 1", d_vld); end
        d_unmapped = 1'b1;
        tick;
        $display("load unmapped pfn=%h exc=%b", d_pfn, d_exc);
        n_cmp++; if ({d_pfn, d_exc} !== 26'h0) begin n_bad++; $display("FAIL d_unmapped: got %h required 0", {d_pfn, d_exc}); end
        d_unmapped = 1'b0; d_req = 1'b0;
        tick;
        n_cmp++; if (d_vld !== 1'b0) begin n_bad++; $display("FAIL d_vld_drop: got %b required 0", d_vld); end
    endtask

    // Lookup on the commit edge sees the old contents, the next edge the new
    task automatic test_visibility;
        op = 3'b010; index_in = 4'd5; entryhi_in = 32'h00C0_0005;
        entrylo0_in = 32'h0001_1582; entrylo1_in = 32'h0;
        op_valid = 1'b1;
        tick;
        op_valid = 1'b0; i_req = 1'b1; i_va = 20'h00C00; asid = 8'd5;
        tick;
        $display("commit-edge lookup exc=%b op_done=%b", i_exc, op_done);
        n_cmp++; if (op_done !== 1'b1) begin n_bad++; $display("FAIL vis_done: got %b required 1", op_done); end
        n_cmp++; if (i_exc !== 2'b01) begin n_bad++; $display("FAIL vis_old: got %b required 01", i_exc); end
        tick;
        $display("next-edge lookup pfn=%h exc=%b", i_pfn, i_exc);
        n_cmp++; if (i_exc !== 2'b00) begin n_bad++; $display("FAIL vis_new_exc: got %b required 00", i_exc); end
        n_cmp++; if (i_pfn !== 24'h456) begin n_bad++; $display("FAIL vis_new_pfn: got %h required 456", i_pfn); end
        i_req = 1'b0;
    endtask

    task automatic test_random;
        logic [3:0] seq [12];
        seq = '{4'd15, 4'd14, 4'd13, 4'd12, 4'd11, 4'd10, 4'd9, 4'd8, 4'd7, 4'd6, 4'd5, 4'd15};
        wired_in = 4'd4; wired_we = 1'b1;
        tick;
        wired_we = 1'b0;
        for (int k = 0; k < 12; k++) begin
            $display("random step %0d = %0d", k, random_out);
            n_cmp++;
            if (random_out !== seq[k]) begin n_bad++; $display("FAIL random_seq[%0d]: got %0d required %0d", k, random_out, seq[k]); end
            tick;
        end
        for (int n = 0; n < 20 && random_out != 4'd9; n++) tick;
        n_cmp++; if (random_out !== 4'd9) begin n_bad++; $display("FAIL random_reach9: got %0d required 9", random_out); end
        do_op(3'b011, 4'd0, 32'h0246_802A, 32'h02AF_3797, 32'h0155_556B);
        do_op(3'b001, 4'd9, 32'h0, 32'h0, 32'h0);
        n_cmp++; if (rd_entryhi !== 32'h0246_802A) begin n_bad++; $display("FAIL tlbr_hi: got %h required 0246802a", rd_entryhi); end
        n_cmp++; if (rd_entrylo0 !== 32'h02AF_3797) begin n_bad++; $display("FAIL tlbr_lo0: got %h required 02af3797", rd_entrylo0); end
        n_cmp++; if (rd_entrylo1 !== 32'h0155_556B) begin n_bad++; $display("FAIL tlbr_lo1: got %h required 0155556b", rd_entrylo1); end
        do_op(3'b001, 4'd0, 32'h0, 32'h0, 32'h0);
        n_cmp++; if (rd_entrylo0 !== 32'h0) begin n_bad++; $display("FAIL tlbwr_not_idx0: got %h required 0", rd_entrylo0); end
    endtask

    task automatic test_wired_pin;
        wired_in = 4'd15; wired_we = 1'b1;
        tick;
        wired_we = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick;
            $display("pinned random = %0d", random_out);
            n_cmp++;
            if (random_out !== 4'd15) begin n_bad++; $display("FAIL random_pinned[%0d]: got %0d required 15", k, random_out); end
        end
        wired_in = 4'd0; wired_we = 1'b1;
        tick;
        wired_we = 1'b0;
    endtask

    task automatic test_priority;
        do_op(3'b010, 4'd7, 32'h00E0_0001, 32'h0001_DDC2, 32'h0);
        do_op(3'b010, 4'd2, 32'h00E0_0003, 32'h0000_8883, 32'h0000_0001);
        asid = 8'd1; i_req = 1'b1; i_va = 20'h00E00;
        tick;
        $display("ifetch dup va=%h pfn=%h exc=%b", i_va, i_pfn, i_exc);
        n_cmp++; if (i_pfn !== 24'h222) begin n_bad++; $display("FAIL prio_i_pfn: got %h required 222", i_pfn); end
        i_req = 1'b0; asid = 8'd9; d_req = 1'b1; d_va = 20'h00E00;
        tick;
        $display("load global va=%h pfn=%h exc=%b", d_va, d_pfn, d_exc);
        n_cmp++; if ({d_pfn, d_exc} !== {24'h222, 2'b00}) begin n_bad++; $display("FAIL prio_global: got %h required 888", {d_pfn, d_exc}); end
        d_req = 1'b0;
        do_op(3'b100, 4'd0, 32'h00E0_0001, 32'h0, 32'h0);
        n_cmp++; if (probe_index !== 32'h2) begin n_bad++; $display("FAIL prio_probe: got %h required 00000002", probe_index); end
    endtask

    // op_valid held through EXEC must be taken once only
    task automatic test_back_to_back;
        int dones;
        dones = 0;
        op = 3'b100; index_in = 4'd0; entryhi_in = 32'h1FFF_E000;
        op_valid = 1'b1;
        tick;
        n_cmp++; if (op_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_ready: got %b required 0", op_ready); end
        tick;
        if (op_done === 1'b1) dones++;
        op_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick;
            if (op_done === 1'b1) dones++;
        end
        $display("held op_valid: op_done pulses=%0d probe=%h", dones, probe_index);
        n_cmp++; if (dones != 1) begin n_bad++; $display("FAIL b2b_done_count: got %0d required 1", dones); end
        n_cmp++; if (probe_index !== 32'h8000_0000) begin n_bad++; $display("FAIL b2b_probe: got %h required 80000000", probe_index); end
    endtask

    task automatic test_bad_op;
        do_op(3'b100, 4'd0, 32'h00E0_0001, 32'h0, 32'h0);
        do_op(3'b111, 4'd5, 32'h1FFF_E000, 32'h0, 32'h0);
        n_cmp++; if (probe_index !== 32'h2) begin n_bad++; $display("FAIL badop_probe: got %h required 00000002", probe_index); end
        do_op(3'b000, 4'd5, 32'h0, 32'h0, 32'h0);
        n_cmp++; if (rd_entryhi !== 32'h0) begin n_bad++; $display("FAIL badop_rd: got %h required 0", rd_entryhi); end
    endtask

    task automatic test_reset_mid_exec;
        op = 3'b010; index_in = 4'd4; entryhi_in = 32'h0120_0005;
        entrylo0_in = 32'h0000_0002; entrylo1_in = 32'h0000_0002;
        op_valid = 1'b1;
        tick;
        op_valid = 1'b0; rst = 1'b0;
        tick;
        rst = 1'b1;
        n_cmp++; if (op_done !== 1'b0) begin n_bad++; $display("FAIL rmid_done0: got %b required 0", op_done); end
        tick;
        n_cmp++; if (op_done !== 1'b0) begin n_bad++; $display("FAIL rmid_done1: got %b required 0", op_done); end
        n_cmp++; if (random_out !== 4'd14) begin n_bad++; $display("FAIL rmid_random: got %0d required 14", random_out); end
        do_op(3'b001, 4'd4, 32'h0, 32'h0, 32'h0);
        n_cmp++; if ({rd_entrylo0[1], rd_entrylo1[1]} !== 2'b00) begin n_bad++; $display("FAIL rmid_v: got %b required 00", {rd_entrylo0[1], rd_entrylo1[1]}); end
        asid = 8'd5; i_req = 1'b1; i_va = 20'h00800;
        tick;
        $display("lookup after mid-exec reset exc=%b", i_exc);
        n_cmp++; if (i_exc !== 2'b01) begin n_bad++; $display("FAIL rmid_cleared: got %b required 01", i_exc); end
        i_req = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        i_req = 1'b0; i_va = '0; i_unmapped = 1'b0;
        d_req = 1'b0; d_va = '0; d_store = 1'b0; d_unmapped = 1'b0;
        asid = '0; op = '0; op_valid = 1'b0; index_in = '0;
        entryhi_in = '0; entrylo0_in = '0; entrylo1_in = '0;
        wired_we = 1'b0; wired_in = '0;
        test_reset;
        test_lookup_basic;
        test_data;
        test_visibility;
        test_random;
        test_wired_pin;
        test_priority;
        test_back_to_back;
        test_bad_op;
        test_reset_mid_exec;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
